// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, bit-timing helper and 8N1 frame constants.
// Used by uart_rx (and uart_tx).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    function automatic int clks_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: circular buffer with extra-MSB pointers, first-word-fall-through head,
// and the overrun decision for pushes that arrive while full.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BITS,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DATA_WIDTH-1:0]      data_i,
    input  logic                       pop_i,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic                       valid_o,
    output logic                       overrun_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  overrun_q, overrun_d;
    logic                  empty, full, do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = push_i && full && !do_pop;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign data_o    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o   = !empty;
    assign overrun_o = overrun_q;
    assign count_o   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchroniser, bit-timing FSM and receive FIFO with valid/ack pop.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each bit centre.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rx_pin,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_read_ack,
    output logic                          frame_error,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CPB      = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int HALF_BIT = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC_OFF = 1;
`else
    localparam int DEC_OFF = 0;
`endif
    // Majority decisions land one count late; reloading the counter with that offset
    // keeps later bit centres on the nominal grid so the lateness does not accumulate.
    localparam logic [15:0] START_DEC  = 16'(HALF_BIT - 1 + DEC_OFF);
    localparam logic [15:0] BIT_DEC    = 16'(CPB - 1 + DEC_OFF);
    localparam logic [15:0] CNT_RELOAD = 16'(DEC_OFF);
    localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);

    logic            sync1_q, sync2_q;
    logic            line_bit;
    rx_state_e       state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            ferr_q, ferr_d;
    logic            push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx_pin;
            sync2_q <= sync1_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= 2'b11;
        else        hist_q <= {hist_q[0], sync2_q};
    end

    assign line_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
`else
    assign line_bit = sync2_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!sync2_q) state_d = START;
            end
            START: begin
                if (cnt_q == START_DEC) begin
                    cnt_d = CNT_RELOAD;
                    idx_d = '0;
                    state_d = line_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_DEC) begin
                    cnt_d   = CNT_RELOAD;
                    shift_d = {line_bit, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_DEC) begin
                    cnt_d = '0;
                    if (line_bit == STOP_LEVEL) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (sync2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
        end
    end

    assign frame_error = ferr_q;

    uart_rx_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .data_i    (shift_q),
        .pop_i     (rx_read_ack),
        .data_o    (rx_data),
        .valid_o   (rx_valid),
        .overrun_o (overrun),
        .count_o   (fifo_count)
    );

endmodule
